// File: rtl/ahb_lite_master.sv
// AHB-Lite master: converts per-cycle A* requests into pipelined AHB address/data phases.
// Optional build macro AHB_MASTER_ERR_ABORT_EN: an ERROR response cancels the burst in progress.
module ahb_lite_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic          Burst,
  input  logic [1:0]    ATRANS,
  input  logic [AW-1:0] AADDR,
  input  logic          AWRITE,
  input  logic [2:0]    ASIZE,
  input  logic [2:0]    ABURST,
  input  logic [DW-1:0] AWDATA,
  output logic          hold,
  output logic [DW-1:0] ARDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [DW-1:0] HRDATA,
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [1:0]    HTRANS,
  output logic [DW-1:0] HWDATA,
  output logic [3:0]    HPROT,
  output logic          HMASTLOCK
);

  // Request-side transfer codes
  localparam logic [1:0] A_NONSEQ = 2'd1;
  localparam logic [1:0] A_SEQ    = 2'd2;

  // Bus-side transfer codes
  localparam logic [1:0] H_IDLE   = 2'b00;
  localparam logic [1:0] H_NONSEQ = 2'b10;
  localparam logic [1:0] H_SEQ    = 2'b11;

  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [AW-1:0] haddr_reg, haddr_next;
  logic [1:0]    htrans_reg, htrans_next;
  logic          hwrite_reg, hwrite_next;
  logic [2:0]    hsize_reg, hsize_next;
  logic [2:0]    hburst_reg, hburst_next;
  logic [DW-1:0] hwdata_reg, hwdata_next;
  logic [DW-1:0] wdata_pend_reg, wdata_pend_next;
  logic [DW-1:0] ardata_reg, ardata_next;
  logic          data_valid_reg, data_valid_next;
  logic          data_write_reg, data_write_next;
  logic          abort_reg, abort_next;

  logic          err_abort;
  logic          req_active;
  logic          req_seq;
  logic          addr_accept;
  logic [AW-1:0] addr_incr;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_beats;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] next_seq_addr;

`ifdef AHB_MASTER_ERR_ABORT_EN
  assign err_abort = HRESP;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign err_abort    = 1'b0;
`endif

  // Burst address generation; non-wrapping bursts get an all-ones mask (0 - 1).
  always_comb begin
    addr_incr = ADDR_ONE << hsize_reg;
    incr_addr = haddr_reg + addr_incr;
    case (hburst_reg)
      BURST_WRAP4:  wrap_beats = AW'(4);
      BURST_WRAP8:  wrap_beats = AW'(8);
      BURST_WRAP16: wrap_beats = AW'(16);
      default:      wrap_beats = '0;
    endcase
    wrap_mask = (wrap_beats << hsize_reg) - ADDR_ONE;
  end

  // Bits inside the wrap block follow the increment, bits above it stay put.
  generate
    for (genvar gi = 0; gi < AW; gi++) begin : g_wrap_bit
      assign next_seq_addr[gi] = wrap_mask[gi] ? incr_addr[gi] : haddr_reg[gi];
    end
  endgenerate

  assign req_active  = start && ((ATRANS == A_NONSEQ) || (ATRANS == A_SEQ));
  assign req_seq     = start && (ATRANS == A_SEQ) && Burst && !abort_reg;
  assign addr_accept = (htrans_reg != H_IDLE);

  always_comb begin
    haddr_next      = haddr_reg;
    htrans_next     = H_IDLE;
    hwrite_next     = hwrite_reg;
    hsize_next      = hsize_reg;
    hburst_next     = hburst_reg;
    wdata_pend_next = wdata_pend_reg;
    abort_next      = abort_reg;
    if (req_active) begin
      hwrite_next     = AWRITE;
      hsize_next      = ASIZE;
      hburst_next     = ABURST;
      wdata_pend_next = AWDATA;
      abort_next      = 1'b0;
      if (req_seq) begin
        haddr_next  = next_seq_addr;
        htrans_next = H_SEQ;
      end else begin
        haddr_next  = AADDR;
        htrans_next = H_NONSEQ;
      end
    end
  end

  // Data phase: the address phase on the bus now becomes the data phase after this edge.
  always_comb begin
    hwdata_next     = (addr_accept && hwrite_reg) ? wdata_pend_reg : hwdata_reg;
    data_valid_next = addr_accept;
    data_write_next = hwrite_reg;
    ardata_next     = (data_valid_reg && !data_write_reg) ? HRDATA : ardata_reg;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_reg      <= '0;
      htrans_reg     <= H_IDLE;
      hwrite_reg     <= 1'b0;
      hsize_reg      <= '0;
      hburst_reg     <= '0;
      hwdata_reg     <= '0;
      wdata_pend_reg <= '0;
      ardata_reg     <= '0;
      data_valid_reg <= 1'b0;
      data_write_reg <= 1'b0;
      abort_reg      <= 1'b0;
    end else if (HREADY) begin
      haddr_reg      <= haddr_next;
      htrans_reg     <= htrans_next;
      hwrite_reg     <= hwrite_next;
      hsize_reg      <= hsize_next;
      hburst_reg     <= hburst_next;
      hwdata_reg     <= hwdata_next;
      wdata_pend_reg <= wdata_pend_next;
      ardata_reg     <= ardata_next;
      data_valid_reg <= data_valid_next;
      data_write_reg <= data_write_next;
      abort_reg      <= abort_next;
    end else if (err_abort) begin
      // First ERROR cycle: withdraw the pending address and forget the burst.
      htrans_reg <= H_IDLE;
      abort_reg  <= 1'b1;
    end
  end

  assign hold      = ~HREADY;
  assign HADDR     = haddr_reg;
  assign HTRANS    = htrans_reg;
  assign HWRITE    = hwrite_reg;
  assign HSIZE     = hsize_reg;
  assign HBURST    = hburst_reg;
  assign HWDATA    = hwdata_reg;
  assign ARDATA    = ardata_reg;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: vector table with a data-phase scoreboard plus
// hand-written stall, error and reset sequences (error behaviour follows AHB_MASTER_ERR_ABORT_EN).
module tb_ahb_lite_master;

  logic        HCLK_tb;
  logic        HRESETn;
  logic        start, Burst, AWRITE, HREADY, HRESP;
  logic [1:0]  ATRANS;
  logic [31:0] AADDR, AWDATA, HRDATA;
  logic [2:0]  ASIZE, ABURST;
  logic        hold, HWRITE, HMASTLOCK;
  logic [31:0] ARDATA, HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;

  ahb_lite_master #(.AW(32), .DW(32)) dut (
    .HCLK(HCLK_tb), .HRESETn(HRESETn), .start(start), .Burst(Burst), .ATRANS(ATRANS),
    .AADDR(AADDR), .AWRITE(AWRITE), .ASIZE(ASIZE), .ABURST(ABURST), .AWDATA(AWDATA),
    .hold(hold), .ARDATA(ARDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK)
  );

  initial HCLK_tb = 1'b0;
  always #5 HCLK_tb = ~HCLK_tb;

  typedef struct {
    logic        start;
    logic        burst;
    logic [1:0]  atrans;
    logic [31:0] aaddr;
    logic        awrite;
    logic [2:0]  asize;
    logic [2:0]  aburst;
    logic [31:0] awdata;
    logic [1:0]  exp_htrans;
    logic [31:0] exp_haddr;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } sb_t;

  localparam int NVEC = 16;
  vec_t        vecs[NVEC];
  sb_t         sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ecount   = 0;
  logic [31:0] last_rd  = 32'h0;

  function automatic vec_t mk(input logic st, input logic bu, input logic [1:0] at,
                              input logic [31:0] ad, input logic wr, input logic [2:0] sz,
                              input logic [2:0] bt, input logic [31:0] wd,
                              input logic [1:0] eht, input logic [31:0] ead);
    vec_t v;
    v.start = st; v.burst = bu; v.atrans = at; v.aaddr = ad; v.awrite = wr;
    v.asize = sz; v.aburst = bt; v.awdata = wd; v.exp_htrans = eht; v.exp_haddr = ead;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK_tb);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic bu, input logic [1:0] at,
                           input logic [31:0] ad, input logic wr, input logic [2:0] sz,
                           input logic [2:0] bt, input logic [31:0] wd);
    start = st; Burst = bu; ATRANS = at; AADDR = ad; AWRITE = wr;
    ASIZE = sz; ABURST = bt; AWDATA = wd;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive_req(v.start, v.burst, v.atrans, v.aaddr, v.awrite, v.asize, v.aburst, v.awdata);
    foreach (sbq[j]) if (sbq[j].due == ecount + 1 && !sbq[j].wr) HRDATA = sbq[j].addr ^ 32'hA500_0000;
    tick();
    ecount++;
    chk($sformatf("vec%0d_htrans", idx), 32'(HTRANS), 32'(v.exp_htrans));
    chk($sformatf("vec%0d_haddr", idx), HADDR, v.exp_haddr);
    if (v.exp_htrans != 2'b00) chk($sformatf("vec%0d_hwrite", idx), 32'(HWRITE), 32'(v.awrite));
    for (int j = 0; j < sbq.size(); ) begin
      if (sbq[j].due == ecount) begin
        if (sbq[j].wr) begin
          chk($sformatf("vec%0d_hwdata_%08h", idx, sbq[j].addr), HWDATA, sbq[j].data);
        end else begin
          last_rd = sbq[j].addr ^ 32'hA500_0000;
          chk($sformatf("vec%0d_ardata_%08h", idx, sbq[j].addr), ARDATA, last_rd);
        end
        sbq.delete(j);
      end else begin
        j++;
      end
    end
    if (v.exp_htrans != 2'b00)
      sbq.push_back('{wr: v.awrite, addr: v.exp_haddr, data: v.awdata,
                      due: ecount + (v.awrite ? 1 : 2)});
    $display("vec %0d: HTRANS=%0d HADDR=%08h HWDATA=%08h ARDATA=%08h",
             idx, HTRANS, HADDR, HWDATA, ARDATA);
  endtask

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    drive_req(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'd0, 32'h0);

    // start, burst, atrans, aaddr, awrite, asize, aburst, awdata, exp_htrans, exp_haddr
    vecs[0]  = mk(1, 0, 2'd1, 32'h20,       1, 3'd1, 3'd1, 32'h20, 2'd2, 32'h20);
    vecs[1]  = mk(1, 1, 2'd2, 32'h0,        1, 3'd1, 3'd1, 32'h22, 2'd3, 32'h22);
    vecs[2]  = mk(0, 0, 2'd0, 32'h0,        0, 3'd0, 3'd0, 32'h0,  2'd0, 32'h22);
    vecs[3]  = mk(1, 0, 2'd1, 32'h5C,       0, 3'd2, 3'd1, 32'h0,  2'd2, 32'h5C);
    vecs[4]  = mk(1, 1, 2'd2, 32'h0,        0, 3'd2, 3'd1, 32'h0,  2'd3, 32'h60);
    vecs[5]  = mk(0, 0, 2'd0, 32'h0,        0, 3'd0, 3'd0, 32'h0,  2'd0, 32'h60);
    vecs[6]  = mk(1, 0, 2'd1, 32'h38,       0, 3'd2, 3'd2, 32'h0,  2'd2, 32'h38);
    vecs[7]  = mk(1, 1, 2'd2, 32'h0,        0, 3'd2, 3'd2, 32'h0,  2'd3, 32'h3C);
    vecs[8]  = mk(1, 1, 2'd2, 32'h0,        0, 3'd2, 3'd2, 32'h0,  2'd3, 32'h30);
    vecs[9]  = mk(1, 1, 2'd2, 32'h0,        0, 3'd2, 3'd2, 32'h0,  2'd3, 32'h34);
    vecs[10] = mk(1, 1, 2'd3, 32'h1234,     1, 3'd0, 3'd0, 32'h0,  2'd0, 32'h34);
    vecs[11] = mk(1, 0, 2'd1, 32'hFFFFFFFF, 1, 3'd0, 3'd1, 32'hA5, 2'd2, 32'hFFFFFFFF);
    vecs[12] = mk(1, 1, 2'd2, 32'h0,        1, 3'd0, 3'd1, 32'h5A, 2'd3, 32'h00000000);
    vecs[13] = mk(1, 0, 2'd2, 32'h100,      1, 3'd2, 3'd0, 32'h77, 2'd2, 32'h100);
    vecs[14] = mk(0, 0, 2'd0, 32'h0,        0, 3'd0, 3'd0, 32'h0,  2'd0, 32'h100);
    vecs[15] = mk(0, 0, 2'd0, 32'h0,        0, 3'd0, 3'd0, 32'h0,  2'd0, 32'h100);

    tick();
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_ardata", ARDATA, 32'h0);
    chk("rst_hold", 32'(hold), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    // Wait state during a read data phase freezes both pipeline stages.
    drive_req(1, 0, 2'd1, 32'h5C, 0, 3'd2, 3'd1, 32'h0);
    tick();
    chk("stall_ns_haddr", HADDR, 32'h5C);
    drive_req(1, 1, 2'd2, 32'h0, 0, 3'd2, 3'd1, 32'h0);
    tick();
    chk("stall_seq_haddr", HADDR, 32'h60);
    HREADY = 1'b0; HRDATA = 32'hDEAD_BEEF;
    #1 chk("stall_hold_hi", 32'(hold), 32'h1);
    tick();
    chk("stall_haddr_frozen", HADDR, 32'h60);
    chk("stall_htrans_frozen", 32'(HTRANS), 32'h3);
    chk("stall_ardata_frozen", ARDATA, last_rd);
    HREADY = 1'b1; HRDATA = 32'h5C;
    drive_req(0, 0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 32'h0);
    #1 chk("stall_hold_lo", 32'(hold), 32'h0);
    tick();
    chk("stall_rd0", ARDATA, 32'h5C);
    chk("stop_idle", 32'(HTRANS), 32'h0);
    HRDATA = 32'h60;
    tick();
    chk("stall_rd1", ARDATA, 32'h60);
    $display("stall sequence: HADDR=%08h ARDATA=%08h", HADDR, ARDATA);

    // ERROR response during a SEQ burst.
    drive_req(1, 0, 2'd1, 32'h80, 0, 3'd2, 3'd1, 32'h0);
    tick();
    drive_req(1, 1, 2'd2, 32'h200, 0, 3'd2, 3'd1, 32'h0);
    tick();
    chk("err_seq_haddr", HADDR, 32'h84);
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    chk("err_haddr_hold", HADDR, 32'h84);
`ifdef AHB_MASTER_ERR_ABORT_EN
    chk("err_htrans_idle", 32'(HTRANS), 32'h0);
`else
    chk("err_htrans_kept", 32'(HTRANS), 32'h3);
`endif
    HREADY = 1'b1; HRDATA = 32'hE0;
    tick();
    chk("err_ardata", ARDATA, 32'hE0);
`ifdef AHB_MASTER_ERR_ABORT_EN
    chk("err_renonseq_htrans", 32'(HTRANS), 32'h2);
    chk("err_renonseq_haddr", HADDR, 32'h200);
`else
    chk("err_cont_htrans", 32'(HTRANS), 32'h3);
    chk("err_cont_haddr", HADDR, 32'h88);
`endif
    HRESP = 1'b0;
    drive_req(0, 0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 32'h0);
    tick();
    chk("err_end_idle", 32'(HTRANS), 32'h0);
    tick();
    $display("error sequence: HTRANS=%0d HADDR=%08h ARDATA=%08h", HTRANS, HADDR, ARDATA);

    // Asynchronous reset in the middle of a write burst.
    drive_req(1, 0, 2'd1, 32'h40, 1, 3'd2, 3'd1, 32'h99);
    tick();
    drive_req(1, 1, 2'd2, 32'h0, 1, 3'd2, 3'd1, 32'h9A);
    tick();
    chk("pre_rst_hwdata", HWDATA, 32'h99);
    chk("pre_rst_haddr", HADDR, 32'h44);
    #2 HRESETn = 1'b0; HREADY = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'h0);
    chk("arst_haddr", HADDR, 32'h0);
    chk("arst_hwdata", HWDATA, 32'h0);
    chk("arst_ardata", ARDATA, 32'h0);
    chk("arst_hwrite", 32'(HWRITE), 32'h0);
    chk("arst_hsize", 32'(HSIZE), 32'h0);
    chk("arst_hold", 32'(hold), 32'h1);
    HRESETn = 1'b1; HREADY = 1'b1;
    drive_req(0, 0, 2'd0, 32'h0, 0, 3'd0, 3'd0, 32'h0);
    tick();
    chk("post_rst_idle", 32'(HTRANS), 32'h0);
    $display("reset sequence: HTRANS=%0d HADDR=%08h", HTRANS, HADDR);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
